// File: rtl/stopwatch_ctrl.sv
// mm:ss BCD stopwatch controller: 1 s prescaler, IDLE/RUN/PAUSE/SET sequencer and manual time set.
// Button inputs are single-cycle pulses from the debounce stage.
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       set_mode,
    input  logic       set_sel,
    input  logic       set_inc,
    output logic [3:0] sec_lo,
    output logic [3:0] sec_hi,
    output logic [3:0] min_lo,
    output logic [3:0] min_hi,
    output logic [1:0] state,
    output logic       set_field,
    output logic       tick,
    output logic       rollover
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(TICK_DIV - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_SET   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          field_q, field_d;
    logic [CW-1:0] div_q, div_d;
    logic [7:0]    sec_q, sec_d;
    logic [7:0]    min_q, min_d;

    // Two-digit BCD increment modulo 60 ({tens, units}).
    function automatic logic [7:0] bcd60_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1;
        end else begin
            r[3:0] = v[3:0] + 4'd1;
            r[7:4] = v[7:4];
        end
        return r;
    endfunction

    assign tick     = (state_q == ST_RUN) && (div_q == DIV_LAST);
    assign rollover = tick && (sec_q == 8'h59) && (min_q == 8'h59);

    always_comb begin
        state_d = state_q;
        field_d = field_q;
        div_d   = div_q;
        sec_d   = sec_q;
        min_d   = min_q;

        // Counting runs off the current state; a pause request still lets this cycle's tick land.
        if (state_q == ST_RUN) begin
            div_d = tick ? '0 : div_q + CW'(1);
        end
        if (tick) begin
            sec_d = bcd60_inc(sec_q);
            if (sec_q == 8'h59) begin
                min_d = bcd60_inc(min_q);
            end
        end

        if (clear) begin
            state_d = ST_IDLE;
            field_d = 1'b0;
            div_d   = '0;
            sec_d   = 8'h00;
            min_d   = 8'h00;
        end else if (set_mode) begin
            if (state_q == ST_IDLE || state_q == ST_PAUSE) begin
                state_d = ST_SET;
                field_d = 1'b0;
                div_d   = '0;
            end else if (state_q == ST_SET) begin
                state_d = ST_PAUSE;
            end
        end else if (start_stop) begin
            if (state_q == ST_IDLE || state_q == ST_PAUSE) begin
                state_d = ST_RUN;
            end else if (state_q == ST_RUN) begin
                state_d = ST_PAUSE;
            end
        end else if (state_q == ST_SET) begin
            if (set_sel) begin
                field_d = ~field_q;
            end else if (set_inc) begin
                if (field_q) begin
                    min_d = bcd60_inc(min_q);
                end else begin
                    sec_d = bcd60_inc(sec_q);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            field_q <= 1'b0;
            div_q   <= '0;
            sec_q   <= 8'h00;
            min_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            field_q <= field_d;
            div_q   <= div_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
        end
    end

    assign sec_lo    = sec_q[3:0];
    assign sec_hi    = sec_q[7:4];
    assign min_lo    = min_q[3:0];
    assign min_hi    = min_q[7:4];
    assign state     = state_q;
    assign set_field = field_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV = 4; inputs change 1 ns after posedge,
// outputs are read on the negedge or 1 ns after the posedge.
module tb_stopwatch_ctrl;

    logic       clk;
    logic       rst;
    logic       start_stop;
    logic       clear;
    logic       set_mode;
    logic       set_sel;
    logic       set_inc;
    logic [3:0] sec_lo, sec_hi, min_lo, min_hi;
    logic [1:0] state;
    logic       set_field, tick, rollover;

    int n_tests = 0;
    int n_fail  = 0;

    stopwatch_ctrl #(.TICK_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_stop (start_stop),
        .clear      (clear),
        .set_mode   (set_mode),
        .set_sel    (set_sel),
        .set_inc    (set_inc),
        .sec_lo     (sec_lo),
        .sec_hi     (sec_hi),
        .min_lo     (min_lo),
        .min_hi     (min_hi),
        .state      (state),
        .set_field  (set_field),
        .tick       (tick),
        .rollover   (rollover)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] mmss();
        return {min_hi, min_lo, sec_hi, sec_lo};
    endfunction

    // mask bits: {set_inc, set_sel, set_mode, clear, start_stop}
    task automatic pulse(input logic [4:0] mask);
        {set_inc, set_sel, set_mode, clear, start_stop} = mask;
        @(posedge clk);
        #1;
        {set_inc, set_sel, set_mode, clear, start_stop} = 5'b0;
    endtask

    task automatic pulse_n(input logic [4:0] mask, input int n);
        for (int i = 0; i < n; i++) pulse(mask);
    endtask

    // Counts negedges until tick is seen (bounded), then steps past the tick edge.
    task automatic step_tick(output int cyc, output int rolls);
        logic found;
        found = 1'b0;
        cyc   = 0;
        rolls = 0;
        while (!found && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (rollover === 1'b1) rolls++;
            if (tick === 1'b1) found = 1'b1;
        end
        if (found) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_tests++;
        if (state !== 2'd0) begin
            n_fail++; $display("FAIL reset_state: got %0d expected 0", state);
        end
        n_tests++;
        if (mmss() !== 16'h0000) begin
            n_fail++; $display("FAIL reset_time: got %04h expected 0000", mmss());
        end
        n_tests++;
        if ({tick, rollover, set_field} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %03b expected 000", {tick, rollover, set_field});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_first_tick();
        int cyc, rolls;
        pulse(5'b00001);
        n_tests++;
        if (state !== 2'd1) begin
            n_fail++; $display("FAIL start_state: got %0d expected 1", state);
        end
        step_tick(cyc, rolls);
        n_tests++;
        if (cyc !== 4) begin
            n_fail++; $display("FAIL first_tick_latency: got %0d expected 4", cyc);
        end
        n_tests++;
        if (mmss() !== 16'h0001) begin
            n_fail++; $display("FAIL first_tick_time: got %04h expected 0001", mmss());
        end
        for (int i = 0; i < 9; i++) step_tick(cyc, rolls);
        n_tests++;
        if (mmss() !== 16'h0010) begin
            n_fail++; $display("FAIL ten_ticks: got %04h expected 0010", mmss());
        end
    endtask

    task automatic test_pause();
        int cyc, rolls, bad;
        do_reset();
        pulse(5'b00001);
        for (int i = 0; i < 59; i++) step_tick(cyc, rolls);
        n_tests++;
        if (mmss() !== 16'h0059) begin
            n_fail++; $display("FAIL run_59: got %04h expected 0059", mmss());
        end
        // Pause edge still advances div_cnt 0 -> 1.
        pulse(5'b00001);
        bad = 0;
        repeat (7) begin
            @(negedge clk);
            if (state !== 2'd2 || mmss() !== 16'h0059 || tick !== 1'b0) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL pause_hold: got %0d bad cycles expected 0", bad);
        end
        @(posedge clk);
        #1;
        pulse(5'b00001);
        step_tick(cyc, rolls);
        n_tests++;
        if (cyc !== 3) begin
            n_fail++; $display("FAIL resume_latency: got %0d expected 3", cyc);
        end
        n_tests++;
        if (mmss() !== 16'h0100) begin
            n_fail++; $display("FAIL resume_time: got %04h expected 0100", mmss());
        end
    endtask

    task automatic test_set_rollover();
        int cyc, rolls, bad;
        pulse(5'b00010);
        pulse(5'b00001);
        pulse(5'b00001);
        n_tests++;
        if (state !== 2'd2 || mmss() !== 16'h0000) begin
            n_fail++; $display("FAIL paused_zero: got state %0d time %04h expected 2 0000", state, mmss());
        end
        pulse(5'b00100);
        n_tests++;
        if (state !== 2'd3 || set_field !== 1'b0) begin
            n_fail++; $display("FAIL enter_set: got %0d/%0b expected 3/0", state, set_field);
        end
        bad = 0;
        pulse(5'b01000);
        for (int i = 0; i < 59; i++) begin
            pulse(5'b10000);
            if (tick !== 1'b0 || rollover !== 1'b0) bad++;
        end
        pulse(5'b01000);
        for (int i = 0; i < 59; i++) begin
            pulse(5'b10000);
            if (tick !== 1'b0 || rollover !== 1'b0) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL set_no_tick: got %0d ticks expected 0", bad);
        end
        n_tests++;
        if (mmss() !== 16'h5959) begin
            n_fail++; $display("FAIL set_5959: got %04h expected 5959", mmss());
        end
        pulse(5'b00100);
        n_tests++;
        if (state !== 2'd2) begin
            n_fail++; $display("FAIL leave_set: got %0d expected 2", state);
        end
        pulse(5'b00001);
        step_tick(cyc, rolls);
        n_tests++;
        if (cyc !== 4 || rolls !== 1) begin
            n_fail++; $display("FAIL rollover_pulse: got cyc %0d rolls %0d expected 4 1", cyc, rolls);
        end
        @(negedge clk);
        n_tests++;
        if (mmss() !== 16'h0000 || state !== 2'd1 || rollover !== 1'b0) begin
            n_fail++; $display("FAIL after_rollover: got %04h st %0d ro %0b expected 0000 1 0",
                               mmss(), state, rollover);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_priority();
        int cyc, rolls;
        pulse(5'b00011);
        n_tests++;
        if (state !== 2'd0 || mmss() !== 16'h0000) begin
            n_fail++; $display("FAIL clear_wins: got state %0d time %04h expected 0 0000", state, mmss());
        end
        pulse(5'b00001);
        step_tick(cyc, rolls);
        pulse(5'b00100);
        n_tests++;
        if (state !== 2'd1 || mmss() !== 16'h0001) begin
            n_fail++; $display("FAIL setmode_in_run: got state %0d time %04h expected 1 0001", state, mmss());
        end
    endtask

    task automatic test_set_fields();
        pulse(5'b00001);
        pulse(5'b00100);
        pulse_n(5'b10000, 8);
        n_tests++;
        if (mmss() !== 16'h0009) begin
            n_fail++; $display("FAIL set_sec_09: got %04h expected 0009", mmss());
        end
        pulse(5'b10000);
        n_tests++;
        if (mmss() !== 16'h0010) begin
            n_fail++; $display("FAIL set_sec_10: got %04h expected 0010", mmss());
        end
        pulse(5'b01000);
        pulse_n(5'b10000, 59);
        n_tests++;
        if (mmss() !== 16'h5910 || set_field !== 1'b1) begin
            n_fail++; $display("FAIL set_min_59: got %04h f%0b expected 5910 f1", mmss(), set_field);
        end
        pulse(5'b10000);
        n_tests++;
        if (mmss() !== 16'h0010) begin
            n_fail++; $display("FAIL set_min_wrap: got %04h expected 0010", mmss());
        end
        pulse(5'b00001);
        n_tests++;
        if (state !== 2'd3) begin
            n_fail++; $display("FAIL startstop_in_set: got %0d expected 3", state);
        end
        // set_sel beats set_inc in the same cycle
        pulse(5'b11000);
        n_tests++;
        if (set_field !== 1'b0 || mmss() !== 16'h0010) begin
            n_fail++; $display("FAIL sel_over_inc: got f%0b %04h expected f0 0010", set_field, mmss());
        end
    endtask

    task automatic test_reset_mid_run();
        int bad;
        pulse(5'b01000);
        pulse_n(5'b10000, 3);
        pulse(5'b01000);
        pulse_n(5'b10000, 17);
        pulse(5'b01000);
        pulse(5'b00100);
        pulse(5'b00001);
        n_tests++;
        if (state !== 2'd1 || mmss() !== 16'h0327 || set_field !== 1'b1) begin
            n_fail++; $display("FAIL run_0327: got st %0d %04h f%0b expected 1 0327 f1",
                               state, mmss(), set_field);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_tests++;
        if (state !== 2'd0 || mmss() !== 16'h0000 || tick !== 1'b0 || set_field !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_run: got st %0d %04h t%0b f%0b expected 0 0000 t0 f0",
                               state, mmss(), tick, set_field);
        end
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (tick !== 1'b0 || mmss() !== 16'h0000) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL idle_quiet: got %0d bad cycles expected 0", bad);
        end
    endtask

    initial begin
        rst        = 1'b1;
        start_stop = 1'b0;
        clear      = 1'b0;
        set_mode   = 1'b0;
        set_sel    = 1'b0;
        set_inc    = 1'b0;
        test_reset();
        test_first_tick();
        test_pause();
        test_set_rollover();
        test_priority();
        test_set_fields();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
